state_enc_compress: RTL
=======================

# state_enc_compress

Encryption back end of the Kyber512 datapath. It sits directly downstream of the INTT stage and consumes its 128-bit push stream: V at word addresses 0–31, Bp0 at 32–63, Bp1 at 64–95. For each pushed word it adds the matching error/message word, reduces the sum mod q, and compresses each coefficient (d=4 for V, d=10 for Bp). It bit-packs the results and writes the 48-word, 768-byte ciphertext buffer.

## Interface
Parameters:
- KYBER_Q, 3329, modulus
- KYBER_DU, 10, Bp compression bits
- KYBER_DV, 4, V compression bits
- W_WIDTH, 128, input/output word width

Ports:
- clk  in  1  clock
- rst  in  1  reset; **one clock; reset is synchronous and active-high**
- enable  in  1  start pulse; accepted only in IDLE
- INTT_Enc_BpV_DecMp_outready  in  1  push strobe from the INTT stage
- INTT_Enc_BpV_DecMp_WAd  in  7  push word address, 0–95
- INTT_Enc_BpV_DecMp1_WData  in  128  8 coefficients; coefficient i at bits [16i+15:16i], i.e. poly index 8·(WAd mod 32)+i
- Err_WData  in  128  addend word (e1/e2+m), valid in the same cycle as the push, same layout
- Ct_outready  out  1  ciphertext write strobe
- Ct_WAd  out  6  0–19 Bp0, 20–39 Bp1, 40–47 V
- Ct_WData  out  128  packed ciphertext word
- Function_done  out  1  one-cycle pulse when all 48 words are written
- Seq_err  out  1  sticky protocol-error flag

## Operation
- FSM states: IDLE, RUN.
  - IDLE→RUN on enable.
  - RUN→IDLE in the cycle after the 48th Ct write.
  - Pushes in IDLE are ignored.
  - enable in RUN is ignored.
- Expected push order is a strict sequence: WAd 0,1,…,95. Gaps between pushes are allowed.
- A push with WAd ≠ expected:
  - sets Seq_err;
  - drops the word;
  - leaves the expected counter unchanged.
- Seq_err clears on rst or on an accepted enable.
- Stage 1 (add/reduce): s = x + e with x, e ∈ [0, q−1]. If s ≥ q, subtract q. Result is 12 bits. Inputs ≥ q are out of contract.
- Stage 2 (compress): c = floor((s·2^d + 1664)/3329) mod 2^d.
  - d = 4 when WAd < 32, else 10.
  - Must be exact for all s ∈ [0, 3328]. A constant multiply-shift is permitted only if it is exhaustively equivalent.
- Stage 3 (pack):
  - LSB-first bit stream per segment: coefficient j occupies stream bits [j·d+d−1 : j·d].
  - Accumulator holds at most 127+80 = 207 bits. Each push appends 32 (V) or 80 (Bp) bits.
  - When ≥128 bits are held, emit the low 128 and shift down.
  - Segments end word-aligned (32·32 = 8·128 and 32·80 = 20·128), so the accumulator is empty at every segment boundary.
- Ct_WAd = segment base (V 40, Bp0 0, Bp1 20) + per-segment output counter. The counter resets at each segment start.
- rst mid-operation:
  - all state returns to IDLE;
  - accumulator and counters clear;
  - any partial output is abandoned.

## Timing
- Reset values: Ct_outready 0, Ct_WAd 0, Ct_WData 0, Function_done 0, Seq_err 0. FSM is in IDLE.
- Pipeline is 3 registered stages. A push at cycle t that completes a 128-bit word produces Ct_outready=1 at cycle t+3, with Ct_WAd/Ct_WData valid in the same cycle.
- At most one Ct write per cycle. Max input rate is 80 bits/cycle, below 128, so no backpressure is needed and none exists.
- Function_done rises one cycle after the final Ct write, i.e. last push (WAd 95) at t gives Function_done at t+4. The FSM is in IDLE in the same cycle.
- Ct_outready is high only in emit cycles. Ct_WData holds its last value otherwise.

## Structure
- Shared package kyber_pkg holds:
  - KYBER_Q, KYBER_DU, KYBER_DV;
  - segment base constants (CT_BP0_BASE 0, CT_BP1_BASE 20, CT_V_BASE 40);
  - word-address segment limits 32/64/96.
- One sub-module, state_enc_compress__coef: combinational add, reduce and compress for a single coefficient with a d-select input, instantiated ×8.
- FSM, counters and packer live in the top module.

## Test plan
- Zero stream: enable, then 96 pushes of all-zero x and e → 48 Ct writes, all data 0. Write order is WAd 40–47, then 0–39. Function_done fires 4 cycles after the last push.
- Midpoint: every x = 1664, e = 0.
  - V words (Ct 40–47) equal 0x8888…8 (all nibbles 8).
  - Bp words have every 10-bit field = 0x200.
- Reduction and wrap: x = 3000, e = 1000 → s = 671. V nibble = 3; Bp field = floor((671·1024+1664)/3329) = 206. x = 3328, e = 0 compresses to 0 for both d=4 and d=10.
- Exhaustive compress: sweep s = 0…3328 through Bp and V coefficient slots, with random gaps between pushes → fields match the golden model bit-exactly.
- Protocol error: a push with WAd 5 while 4 is expected → Seq_err=1, the word is dropped, and the sequence continues correctly from 4. A new enable clears Seq_err.
- Reset mid-run: assert rst after 40 pushes → all outputs return to reset values next cycle. A fresh full run then produces a correct 48-word ciphertext.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber512 constants, ciphertext layout and segment helpers.
package kyber_pkg;

    localparam int unsigned KYBER_Q  = 3329;
    localparam int unsigned KYBER_DU = 10;
    localparam int unsigned KYBER_DV = 4;
    localparam int unsigned W_WIDTH  = 128;

    // Ciphertext word base of each segment
    localparam logic [5:0] CT_BP0_BASE  = 6'd0;
    localparam logic [5:0] CT_BP1_BASE  = 6'd20;
    localparam logic [5:0] CT_V_BASE    = 6'd40;
    localparam logic [5:0] CT_LAST_WORD = 6'd47;

    // Push word-address segment limits (exclusive upper bounds)
    localparam logic [6:0] WAD_V_END   = 7'd32;
    localparam logic [6:0] WAD_BP0_END = 7'd64;
    localparam logic [6:0] WAD_BP1_END = 7'd96;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SEG_V   = 2'd0,
        SEG_BP0 = 2'd1,
        SEG_BP1 = 2'd2
    } seg_e;

    function automatic seg_e seg_of_wad(input logic [6:0] wad);
        seg_e seg;
        if (wad < WAD_V_END) begin
            seg = SEG_V;
        end else if (wad < WAD_BP0_END) begin
            seg = SEG_BP0;
        end else begin
            seg = SEG_BP1;
        end
        return seg;
    endfunction

    function automatic logic [5:0] seg_base(input seg_e seg);
        logic [5:0] base;
        case (seg)
            SEG_V:   base = CT_V_BASE;
            SEG_BP0: base = CT_BP0_BASE;
            SEG_BP1: base = CT_BP1_BASE;
            default: base = CT_BP0_BASE;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/state_enc_compress__coef.sv
// One coefficient: add error term, reduce mod q, compress to D_HI or D_LO bits.
// Compression divides by the constant q directly, so it is exact for every s.
module state_enc_compress__coef #(
    parameter int unsigned Q    = 3329,
    parameter int unsigned D_HI = 10,
    parameter int unsigned D_LO = 4
) (
    input  logic [15:0]     x_i,
    input  logic [15:0]     e_i,
    input  logic            d_hi_i,
    output logic [D_HI-1:0] c_o
);

    localparam logic [16:0] Q17     = 17'(Q);
    localparam logic [23:0] Q24     = 24'(Q);
    localparam logic [23:0] HALF24  = 24'(Q / 2);
    localparam logic [23:0] MASK_HI = 24'((1 << D_HI) - 1);
    localparam logic [23:0] MASK_LO = 24'((1 << D_LO) - 1);

    logic [16:0] sum_s;
    logic [11:0] red_s;
    logic [23:0] num_s;
    logic [23:0] quo_s;

    // Modular add then rounded division by q, masked to the selected width
    always_comb begin
        sum_s = {1'b0, x_i} + {1'b0, e_i};
        if (sum_s >= Q17) begin
            red_s = 12'(sum_s - Q17);
        end else begin
            red_s = sum_s[11:0];
        end
        if (d_hi_i) begin
            num_s = ({12'd0, red_s} << D_HI) + HALF24;
        end else begin
            num_s = ({12'd0, red_s} << D_LO) + HALF24;
        end
        quo_s = num_s / Q24;
        if (d_hi_i) begin
            c_o = D_HI'(quo_s & MASK_HI);
        end else begin
            c_o = D_HI'(quo_s & MASK_LO);
        end
    end

endmodule

// File: rtl/state_enc_compress.sv
// Kyber512 encryption back end: add/reduce/compress each pushed word and
// bit-pack the results into the 48-word ciphertext buffer.
module state_enc_compress
    import kyber_pkg::*;
#(
    parameter int unsigned KYBER_Q  = kyber_pkg::KYBER_Q,
    parameter int unsigned KYBER_DU = kyber_pkg::KYBER_DU,
    parameter int unsigned KYBER_DV = kyber_pkg::KYBER_DV,
    parameter int unsigned W_WIDTH  = kyber_pkg::W_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               INTT_Enc_BpV_DecMp_outready,
    input  logic [6:0]         INTT_Enc_BpV_DecMp_WAd,
    input  logic [W_WIDTH-1:0] INTT_Enc_BpV_DecMp1_WData,
    input  logic [W_WIDTH-1:0] Err_WData,
    output logic               Ct_outready,
    output logic [5:0]         Ct_WAd,
    output logic [W_WIDTH-1:0] Ct_WData,
    output logic               Function_done,
    output logic               Seq_err
);

    localparam int unsigned CHUNK_W = 8 * KYBER_DU;
    localparam int unsigned ACC_W   = W_WIDTH - 1 + CHUNK_W;

    // Control
    state_e             state_q, state_d;
    logic [6:0]         exp_q, exp_d;
    logic               seq_err_q, seq_err_d;
    logic               accept_s, start_s;

    // Stage 1: captured push
    logic               s1_valid_q, s1_valid_d;
    logic [W_WIDTH-1:0] s1_x_q, s1_x_d, s1_e_q, s1_e_d;
    logic               s1_hi_q, s1_hi_d, s1_first_q, s1_first_d;
    seg_e               s1_seg_q, s1_seg_d;

    // Stage 2: compressed chunk
    logic [KYBER_DU-1:0] c_s [8];
    logic               s2_valid_q, s2_valid_d;
    logic [CHUNK_W-1:0] s2_chunk_q, s2_chunk_d;
    logic               s2_hi_q, s2_hi_d, s2_first_q, s2_first_d;
    seg_e               s2_seg_q, s2_seg_d;

    // Stage 3: packer and output registers
    logic [ACC_W-1:0]   acc_q, acc_d, merged_s;
    logic [7:0]         fill_q, fill_d, fill_sum_s;
    logic [4:0]         cnt_q, cnt_d;
    logic [5:0]         wr_cnt_q, wr_cnt_d;
    logic               last_q, last_d;
    logic               out_valid_q, out_valid_d;
    logic [5:0]         out_wad_q, out_wad_d;
    logic [W_WIDTH-1:0] out_data_q, out_data_d;
    logic               done_q, done_d;

    // FSM next state, in-order push acceptance and sticky protocol error
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        seq_err_d = seq_err_q;
        accept_s  = 1'b0;
        start_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d   = ST_RUN;
                    exp_d     = 7'd0;
                    seq_err_d = 1'b0;
                    start_s   = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
                if (INTT_Enc_BpV_DecMp_outready) begin
                    if ((INTT_Enc_BpV_DecMp_WAd == exp_q) && (exp_q < WAD_BP1_END)) begin
                        accept_s = 1'b1;
                        exp_d    = exp_q + 7'd1;
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end else begin
                    accept_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stage 1 capture: hold data when nothing is accepted to avoid toggling
    always_comb begin
        s1_valid_d = accept_s;
        s1_x_d     = s1_x_q;
        s1_e_d     = s1_e_q;
        s1_hi_d    = s1_hi_q;
        s1_first_d = s1_first_q;
        s1_seg_d   = s1_seg_q;
        if (accept_s) begin
            s1_x_d     = INTT_Enc_BpV_DecMp1_WData;
            s1_e_d     = Err_WData;
            s1_seg_d   = seg_of_wad(INTT_Enc_BpV_DecMp_WAd);
            s1_hi_d    = (seg_of_wad(INTT_Enc_BpV_DecMp_WAd) != SEG_V);
            s1_first_d = (INTT_Enc_BpV_DecMp_WAd[4:0] == 5'd0);
        end else begin
            s1_valid_d = 1'b0;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_coef
        state_enc_compress__coef #(
            .Q    (KYBER_Q),
            .D_HI (KYBER_DU),
            .D_LO (KYBER_DV)
        ) u_coef (
            .x_i    (s1_x_q[16*g +: 16]),
            .e_i    (s1_e_q[16*g +: 16]),
            .d_hi_i (s1_hi_q),
            .c_o    (c_s[g])
        );
    end

    // Stage 2: concatenate the eight compressed fields LSB-first
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_hi_d    = s1_hi_q;
        s2_first_d = s1_first_q;
        s2_seg_d   = s1_seg_q;
        s2_chunk_d = {CHUNK_W{1'b0}};
        for (int i = 0; i < 8; i++) begin
            if (s1_hi_q) begin
                s2_chunk_d[i*KYBER_DU +: KYBER_DU] = c_s[i];
            end else begin
                s2_chunk_d[i*KYBER_DV +: KYBER_DV] = c_s[i][KYBER_DV-1:0];
            end
        end
    end

    // Stage 3: append chunk to accumulator, emit one 128-bit word when full
    always_comb begin
        acc_d       = acc_q;
        fill_d      = fill_q;
        cnt_d       = cnt_q;
        wr_cnt_d    = wr_cnt_q;
        last_d      = 1'b0;
        out_valid_d = 1'b0;
        out_wad_d   = out_wad_q;
        out_data_d  = out_data_q;
        merged_s    = acc_q | (ACC_W'(s2_chunk_q) << fill_q);
        if (s2_hi_q) begin
            fill_sum_s = fill_q + 8'(CHUNK_W);
        end else begin
            fill_sum_s = fill_q + 8'(8 * KYBER_DV);
        end
        if (start_s) begin
            acc_d    = {ACC_W{1'b0}};
            fill_d   = 8'd0;
            cnt_d    = 5'd0;
            wr_cnt_d = 6'd0;
        end else if (s2_valid_q) begin
            if (fill_sum_s >= 8'(W_WIDTH)) begin
                out_valid_d = 1'b1;
                out_data_d  = merged_s[W_WIDTH-1:0];
                acc_d       = merged_s >> W_WIDTH;
                fill_d      = fill_sum_s - 8'(W_WIDTH);
                wr_cnt_d    = wr_cnt_q + 6'd1;
                last_d      = (wr_cnt_q == CT_LAST_WORD);
                if (s2_first_q) begin
                    out_wad_d = seg_base(s2_seg_q);
                    cnt_d     = 5'd1;
                end else begin
                    out_wad_d = seg_base(s2_seg_q) + {1'b0, cnt_q};
                    cnt_d     = cnt_q + 5'd1;
                end
            end else begin
                acc_d  = merged_s;
                fill_d = fill_sum_s;
                if (s2_first_q) begin
                    cnt_d = 5'd0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Completion pulse follows the final ciphertext write by one cycle
    always_comb begin
        done_d = last_q;
    end

    // All pipeline, packer and control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            exp_q       <= 7'd0;
            seq_err_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_x_q      <= {W_WIDTH{1'b0}};
            s1_e_q      <= {W_WIDTH{1'b0}};
            s1_hi_q     <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_seg_q    <= SEG_V;
            s2_valid_q  <= 1'b0;
            s2_chunk_q  <= {CHUNK_W{1'b0}};
            s2_hi_q     <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_seg_q    <= SEG_V;
            acc_q       <= {ACC_W{1'b0}};
            fill_q      <= 8'd0;
            cnt_q       <= 5'd0;
            wr_cnt_q    <= 6'd0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_wad_q   <= 6'd0;
            out_data_q  <= {W_WIDTH{1'b0}};
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            seq_err_q   <= seq_err_d;
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_e_q      <= s1_e_d;
            s1_hi_q     <= s1_hi_d;
            s1_first_q  <= s1_first_d;
            s1_seg_q    <= s1_seg_d;
            s2_valid_q  <= s2_valid_d;
            s2_chunk_q  <= s2_chunk_d;
            s2_hi_q     <= s2_hi_d;
            s2_first_q  <= s2_first_d;
            s2_seg_q    <= s2_seg_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            cnt_q       <= cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_wad_q   <= out_wad_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign Ct_outready   = out_valid_q;
    assign Ct_WAd        = out_wad_q;
    assign Ct_WData      = out_data_q;
    assign Function_done = done_q;
    assign Seq_err       = seq_err_q;

endmodule
